jtopl_eg_state: RTL



---
 rtl/jtopl_eg_pkg.sv | 19 +
 rtl/jtopl_slot_sh.sv | 40 ++++
 rtl/jtopl_eg_state.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/jtopl_eg_pkg.sv
// Shared encodings and helpers for the OPL envelope-generator state store.
// Holds the envelope phase encoding, the silent attenuation value and the sustain-level expansion.
package jtopl_eg_pkg;

  typedef enum logic [1:0] {
    StAttack  = 2'd0,
    StDecay   = 2'd1,
    StSustain = 2'd2,
    StRelease = 2'd3
  } eg_state_e;

  localparam logic [8:0] MAX_ATT = 9'h1FF;

  // Sustain level 15 maps to the very bottom of the attenuation range.
  function automatic logic [4:0] slx_expand(input logic [3:0] sl);
    return (sl == 4'hF) ? 5'h1F : {1'b0, sl};
  endfunction

endpackage

// File: rtl/jtopl_slot_sh.sv
// SLOTS-deep circular shift register: entry 0 is the slot being processed, the written value
// re-appears at the head after Slots enabled cycles.
module jtopl_slot_sh #(
  parameter int unsigned       Width    = 1,
  parameter int unsigned       Slots    = 18,
  parameter logic [Width-1:0]  ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cen_i,
  input  logic [Width-1:0] din_i,
  output logic [Width-1:0] head_o
);

  logic [Width-1:0] mem_q [Slots];
  logic [Width-1:0] mem_d [Slots];

  always_comb begin
    mem_d = mem_q;
    if (cen_i) begin
      for (int unsigned i = 0; i < Slots - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      mem_d[Slots-1] = din_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Slots; i++) begin
        mem_q[i] <= ResetVal;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign head_o = mem_q[0];

endmodule

// File: rtl/jtopl_eg_state.sv
// Per-slot envelope state machine and attenuation store; owns the global envelope counter and
// hands the current slot's base rate to the external step stage.
module jtopl_eg_state
  import jtopl_eg_pkg::*;
#(
  parameter int unsigned SLOTS = 18,
  parameter int unsigned CNT_W = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             zero,
  input  logic             keyon,
  input  logic             eg_sus,
  input  logic [3:0]       ar,
  input  logic [3:0]       dr,
  input  logic [3:0]       rr,
  input  logic [3:0]       sl,
  input  logic             step,
  input  logic [5:0]       rate,
  input  logic             cnt_lsb,
  input  logic             sum_up,
  output logic [CNT_W-1:0] eg_cnt,
  output logic [4:0]       base_rate,
  output logic             attack,
  output logic             cnt_in,
  output logic [8:0]       eg_att
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0] eg_cnt_q, eg_cnt_d;

  logic [1:0] state_head;
  logic [8:0] att_head;
  logic       lsb_head;
  logic       kl_head;

  eg_state_e  state_cur;
  eg_state_e  state_nx;
  logic [8:0] att_upd;
  logic [8:0] att_nx;
  logic [3:0] sel_rate;
  logic [3:0] rate_hi;
  logic [2:0] atk_shift;
  logic [9:0] atk_dec;
  logic [8:0] dec_inc;
  logic [9:0] dec_sum;

  always_comb begin
    eg_cnt_d = eg_cnt_q;
    if (cen && zero) begin
      eg_cnt_d = eg_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eg_cnt_q <= '0;
    end else begin
      eg_cnt_q <= eg_cnt_d;
    end
  end

  // Rate selection and head-derived outputs; nothing here depends on the step stage.
  always_comb begin
    state_cur = eg_state_e'(state_head);
    unique case (state_cur)
      StAttack:  sel_rate = ar;
      StDecay:   sel_rate = dr;
      StSustain: sel_rate = eg_sus ? 4'd0 : rr;
      default:   sel_rate = rr;
    endcase
  end

  assign base_rate = {sel_rate, 1'b0};
  assign attack    = (state_cur == StAttack);
  assign cnt_in    = lsb_head;
  assign eg_att    = att_head;
  assign eg_cnt    = eg_cnt_q;

  // Attenuation step, always judged against the state held before this visit's transition.
  always_comb begin
    rate_hi = rate[5:2];
    if (rate_hi >= 4'd12 && rate_hi <= 4'd14) begin
      atk_shift = 3'd4 - 3'(rate_hi - 4'd11);
    end else begin
      atk_shift = 3'd4;
    end
    if (rate_hi < 4'd12) begin
      dec_inc = 9'd1;
    end else begin
      dec_inc = 9'd1 << (rate_hi - 4'd11);
    end
    atk_dec = {1'b0, att_head >> atk_shift} + 10'd1;
    dec_sum = {1'b0, att_head} + {1'b0, dec_inc};

    att_upd = att_head;
    if (step && sum_up) begin
      if (state_cur == StAttack) begin
        if (att_head != 9'd0) begin
          att_upd = (atk_dec >= {1'b0, att_head}) ? 9'd0 : (att_head - atk_dec[8:0]);
        end
      end else begin
        att_upd = dec_sum[9] ? MAX_ATT : dec_sum[8:0];
      end
    end
  end

  always_comb begin
    state_nx = state_cur;
    att_nx   = att_upd;
    if (!keyon) begin
      state_nx = StRelease;
    end else if (!kl_head) begin
      state_nx = StAttack;
      // Fastest attack rates jump straight to full volume.
      if (rate >= 6'd60) begin
        att_nx   = 9'd0;
        state_nx = StDecay;
      end
    end else if (state_cur == StAttack && att_head == 9'd0) begin
      state_nx = StDecay;
    end else if (state_cur == StDecay && att_head[8:4] >= slx_expand(sl)) begin
      state_nx = StSustain;
    end
  end

  jtopl_slot_sh #(
    .Width    (2),
    .Slots    (SLOTS),
    .ResetVal (2'(StRelease))
  ) u_state_sh (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .cen_i  (cen),
    .din_i  (state_nx),
    .head_o (state_head)
  );

  jtopl_slot_sh #(
    .Width    (9),
    .Slots    (SLOTS),
    .ResetVal (MAX_ATT)
  ) u_att_sh (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .cen_i  (cen),
    .din_i  (att_nx),
    .head_o (att_head)
  );

  jtopl_slot_sh #(
    .Width    (1),
    .Slots    (SLOTS),
    .ResetVal (1'b0)
  ) u_lsb_sh (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .cen_i  (cen),
    .din_i  (cnt_lsb),
    .head_o (lsb_head)
  );

  jtopl_slot_sh #(
    .Width    (1),
    .Slots    (SLOTS),
    .ResetVal (1'b0)
  ) u_kl_sh (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .cen_i  (cen),
    .din_i  (keyon),
    .head_o (kl_head)
  );

endmodule
